// File: rtl/bip_control_unit.sv
// -----------------------------------------------------------------------------
// bip_control_unit
//
// Sequencer and instruction decoder for the BIP accumulator datapath. It holds
// the program counter, fetches instruction words from the synchronous program
// ROM, and decodes each word into the control signals for the accumulator
// multiplexer, the ALU and the data RAM.
//
// Each instruction takes two cycles:
//   FETCH : AddrProg = PC is presented to the ROM. All control outputs are 0.
//   EXEC  : the ROM word is valid on Instr. The decoded controls are driven for
//           this single cycle.
//   HALT  : entered on HLT. Only reset leaves this state.
//
// Ports
//   clk        in   system clock, rising edge
//   reset      in   synchronous, active-high reset
//   Enable     in   allows leaving FETCH (sampled in FETCH only)
//   Instr      in   {opcode, operand[10:0]} from ROM, valid in EXEC
//   AddrProg   out  program ROM address (the PC)
//   Operand    out  Instr[10:0] during EXEC, otherwise 0
//   SelA       out  accumulator mux select: 0=data RAM, 1=immediate, 2=ALU
//   SelB       out  ALU B operand select: 0=RAM data, 1=immediate
//   Op         out  ALU operation: 0=add, 1=sub
//   WrAcc      out  accumulator write strobe
//   WrRam      out  data RAM write strobe
//   RdRam      out  data RAM read strobe
//   Halted     out  high while in HALT
//   InstrCount out  completed-instruction count, saturating
// -----------------------------------------------------------------------------
module bip_control_unit #(
    parameter int unsigned PC_WIDTH     = 11,
    parameter int unsigned OPCODE_WIDTH = 5,
    parameter int unsigned CNT_WIDTH    = 16
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      Enable,
    input  logic [OPCODE_WIDTH+10:0]  Instr,
    output logic [PC_WIDTH-1:0]       AddrProg,
    output logic [10:0]               Operand,
    output logic [1:0]                SelA,
    output logic                      SelB,
    output logic                      Op,
    output logic                      WrAcc,
    output logic                      WrRam,
    output logic                      RdRam,
    output logic                      Halted,
    output logic [CNT_WIDTH-1:0]      InstrCount
);

    // -------------------------------------------------------------------------
    // State encodings
    // -------------------------------------------------------------------------
    localparam logic [1:0] ST_FETCH = 2'd0;
    localparam logic [1:0] ST_EXEC  = 2'd1;
    localparam logic [1:0] ST_HALT  = 2'd2;

    // Opcodes. Every value above SUBI decodes as NOP.
    localparam logic [OPCODE_WIDTH-1:0] OPC_HLT  = OPCODE_WIDTH'(0);
    localparam logic [OPCODE_WIDTH-1:0] OPC_STO  = OPCODE_WIDTH'(1);
    localparam logic [OPCODE_WIDTH-1:0] OPC_LD   = OPCODE_WIDTH'(2);
    localparam logic [OPCODE_WIDTH-1:0] OPC_LDI  = OPCODE_WIDTH'(3);
    localparam logic [OPCODE_WIDTH-1:0] OPC_ADD  = OPCODE_WIDTH'(4);
    localparam logic [OPCODE_WIDTH-1:0] OPC_ADDI = OPCODE_WIDTH'(5);
    localparam logic [OPCODE_WIDTH-1:0] OPC_SUB  = OPCODE_WIDTH'(6);
    localparam logic [OPCODE_WIDTH-1:0] OPC_SUBI = OPCODE_WIDTH'(7);

    // Accumulator mux selects. The value 3 is never driven.
    localparam logic [1:0] SELA_RAM = 2'd0;
    localparam logic [1:0] SELA_IMM = 2'd1;
    localparam logic [1:0] SELA_ALU = 2'd2;

    // -------------------------------------------------------------------------
    // Registers
    // -------------------------------------------------------------------------
    logic [1:0]           state_q, state_d;
    logic [PC_WIDTH-1:0]  pc_q, pc_d;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;

    // -------------------------------------------------------------------------
    // Instruction fields and raw decode
    //
    // The decoder runs on Instr every cycle. Its results are gated to the
    // outputs only in EXEC, so ROM contents seen during FETCH/HALT are harmless.
    // -------------------------------------------------------------------------
    logic [OPCODE_WIDTH-1:0] opcode;
    logic [10:0]             operand_field;

    logic [1:0] dec_sel_a;
    logic       dec_sel_b;
    logic       dec_op;
    logic       dec_wr_acc;
    logic       dec_wr_ram;
    logic       dec_rd_ram;
    logic       dec_hlt;

    assign opcode        = Instr[OPCODE_WIDTH+10:11];
    assign operand_field = Instr[10:0];

    always_comb begin
        dec_sel_a  = SELA_RAM;
        dec_sel_b  = 1'b0;
        dec_op     = 1'b0;
        dec_wr_acc = 1'b0;
        dec_wr_ram = 1'b0;
        dec_rd_ram = 1'b0;
        dec_hlt    = 1'b0;

        case (opcode)
            OPC_HLT: begin
                dec_hlt = 1'b1;
            end
            OPC_STO: begin
                dec_wr_ram = 1'b1;
            end
            OPC_LD: begin
                dec_rd_ram = 1'b1;
                dec_sel_a  = SELA_RAM;
                dec_wr_acc = 1'b1;
            end
            OPC_LDI: begin
                dec_sel_a  = SELA_IMM;
                dec_wr_acc = 1'b1;
            end
            OPC_ADD: begin
                dec_rd_ram = 1'b1;
                dec_sel_a  = SELA_ALU;
                dec_sel_b  = 1'b0;
                dec_op     = 1'b0;
                dec_wr_acc = 1'b1;
            end
            OPC_ADDI: begin
                dec_sel_a  = SELA_ALU;
                dec_sel_b  = 1'b1;
                dec_op     = 1'b0;
                dec_wr_acc = 1'b1;
            end
            OPC_SUB: begin
                dec_rd_ram = 1'b1;
                dec_sel_a  = SELA_ALU;
                dec_sel_b  = 1'b0;
                dec_op     = 1'b1;
                dec_wr_acc = 1'b1;
            end
            OPC_SUBI: begin
                dec_sel_a  = SELA_ALU;
                dec_sel_b  = 1'b1;
                dec_op     = 1'b1;
                dec_wr_acc = 1'b1;
            end
            default: begin
                // NOP: no strobes, still advances PC and is counted.
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        cnt_d   = cnt_q;

        case (state_q)
            ST_FETCH: begin
                if (Enable) begin
                    state_d = ST_EXEC;
                end
            end
            ST_EXEC: begin
                // Enable is not consulted: an instruction in EXEC always retires.
                if (dec_hlt) begin
                    state_d = ST_HALT;
                end else begin
                    state_d = ST_FETCH;
                    pc_d    = pc_q + PC_WIDTH'(1);
                    if (cnt_q != '1) begin
                        cnt_d = cnt_q + CNT_WIDTH'(1);
                    end
                end
            end
            ST_HALT: begin
                state_d = ST_HALT;
            end
            default: begin
                // Unused encoding: recover to a clean fetch.
                state_d = ST_FETCH;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // State registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_FETCH;
            pc_q    <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            cnt_q   <= cnt_d;
        end
    end

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    logic in_exec;

    assign in_exec = (state_q == ST_EXEC);

    always_comb begin
        SelA    = in_exec ? dec_sel_a     : SELA_RAM;
        SelB    = in_exec & dec_sel_b;
        Op      = in_exec & dec_op;
        WrAcc   = in_exec & dec_wr_acc;
        WrRam   = in_exec & dec_wr_ram;
        RdRam   = in_exec & dec_rd_ram;
        Operand = in_exec ? operand_field : '0;
    end

    assign AddrProg   = pc_q;
    assign Halted     = (state_q == ST_HALT);
    assign InstrCount = cnt_q;

endmodule

// File: tb/tb_bip_control_unit.sv
// -----------------------------------------------------------------------------
// tb_bip_control_unit
//
// Directed bench for bip_control_unit. A synchronous program ROM model feeds
// Instr one cycle after AddrProg. Expected control words are written by hand as
// {SelA[1:0], SelB, Op, WrAcc, WrRam, RdRam}.
// -----------------------------------------------------------------------------
module tb_bip_control_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        Enable;
    logic [15:0] Instr;
    logic [10:0] AddrProg;
    logic [10:0] Operand;
    logic [1:0]  SelA;
    logic        SelB;
    logic        Op;
    logic        WrAcc;
    logic        WrRam;
    logic        RdRam;
    logic        Halted;
    logic [15:0] InstrCount;

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;

    logic [15:0] rom [0:2047];

    bip_control_unit #(
        .PC_WIDTH     (11),
        .OPCODE_WIDTH (5),
        .CNT_WIDTH    (16)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .Enable     (Enable),
        .Instr      (Instr),
        .AddrProg   (AddrProg),
        .Operand    (Operand),
        .SelA       (SelA),
        .SelB       (SelB),
        .Op         (Op),
        .WrAcc      (WrAcc),
        .WrRam      (WrRam),
        .RdRam      (RdRam),
        .Halted     (Halted),
        .InstrCount (InstrCount)
    );

    always #5 clk = ~clk;

    // Synchronous ROM: word appears one cycle after its address.
    always @(posedge clk) Instr <= rom[AddrProg];

    logic [6:0] ctrl;
    assign ctrl = {SelA, SelB, Op, WrAcc, WrRam, RdRam};

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic fill_rom(input logic [15:0] w);
        for (int i = 0; i < 2048; i++) rom[i] = w;
    endtask

    task automatic do_reset();
        reset  = 1'b1;
        Enable = 1'b0;
        tick();
        tick();
        reset  = 1'b0;
    endtask

    // One EXEC cycle then the following FETCH cycle.
    task automatic exec_step(input string tag, input logic [6:0] exp_ctrl,
                             input logic [10:0] exp_opnd, input logic [10:0] exp_next_pc);
        tick();
        check({tag, "_ctrl"}, 32'(ctrl), 32'(exp_ctrl));
        check({tag, "_opnd"}, 32'(Operand), 32'(exp_opnd));
        tick();
        check({tag, "_fetch_ctrl"}, 32'(ctrl), 32'h0);
        check({tag, "_fetch_opnd"}, 32'(Operand), 32'h0);
        check({tag, "_pc"}, 32'(AddrProg), 32'(exp_next_pc));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset  = 1'b1;
        Enable = 1'b0;
        fill_rom(16'hF800);
        tick();

        // Reset then idle with Enable low.
        do_reset();
        check("rst_pc", 32'(AddrProg), 32'h0);
        check("rst_cnt", 32'(InstrCount), 32'h0);
        check("rst_halt", 32'(Halted), 32'h0);
        for (int i = 0; i < 10; i++) begin
            tick();
            check("idle_ctrl", 32'(ctrl), 32'h0);
            check("idle_pc", 32'(AddrProg), 32'h0);
        end
        check("idle_cnt", 32'(InstrCount), 32'h0);

        // LDI / ADDI / SUBI
        rom[0] = 16'h1805;
        rom[1] = 16'h2803;
        rom[2] = 16'h3801;
        do_reset();
        Enable = 1'b1;
        exec_step("ldi",  7'b01_0_0_1_0_0, 11'd5, 11'd1);
        exec_step("addi", 7'b10_1_0_1_0_0, 11'd3, 11'd2);
        exec_step("subi", 7'b10_1_1_1_0_0, 11'd1, 11'd3);
        check("imm_cnt", 32'(InstrCount), 32'd3);

        // Memory operations
        rom[0] = 16'h0810;
        rom[1] = 16'h1010;
        rom[2] = 16'h2011;
        rom[3] = 16'h3012;
        do_reset();
        Enable = 1'b1;
        exec_step("sto", 7'b00_0_0_0_1_0, 11'h010, 11'd1);
        exec_step("ld",  7'b00_0_0_1_0_1, 11'h010, 11'd2);
        exec_step("add", 7'b10_0_0_1_0_1, 11'h011, 11'd3);
        exec_step("sub", 7'b10_0_1_1_0_1, 11'h012, 11'd4);
        check("mem_cnt", 32'(InstrCount), 32'd4);

        // HLT
        fill_rom(16'hF800);
        rom[0] = 16'h1801;
        rom[1] = 16'h0000;
        do_reset();
        Enable = 1'b1;
        exec_step("hlt_ldi", 7'b01_0_0_1_0_0, 11'd1, 11'd1);
        tick();  // cycle 3: EXEC of HLT
        check("hlt_exec_ctrl", 32'(ctrl), 32'h0);
        check("hlt_exec_halted", 32'(Halted), 32'h0);
        tick();  // cycle 4
        check("hlt_halted", 32'(Halted), 32'h1);
        for (int i = 0; i < 20; i++) begin
            tick();
            check("hlt_hold_halted", 32'(Halted), 32'h1);
            check("hlt_hold_pc", 32'(AddrProg), 32'h1);
            check("hlt_hold_ctrl", 32'(ctrl), 32'h0);
        end
        check("hlt_cnt", 32'(InstrCount), 32'h1);
        do_reset();
        check("hlt_rst_halted", 32'(Halted), 32'h0);
        check("hlt_rst_pc", 32'(AddrProg), 32'h0);

        // Stall: Enable 1,0,0,1,0 with NOP ROM.
        fill_rom(16'hF800);
        do_reset();
        Enable = 1'b1; tick();  // EXEC pc0
        check("stall_e0_pc", 32'(AddrProg), 32'd0);
        check("stall_e0_ctrl", 32'(ctrl), 32'h0);
        Enable = 1'b0; tick();  // EXEC completes regardless of Enable
        check("stall_f1_pc", 32'(AddrProg), 32'd1);
        check("stall_f1_cnt", 32'(InstrCount), 32'd1);
        Enable = 1'b0; tick();  // held in FETCH
        check("stall_hold_pc", 32'(AddrProg), 32'd1);
        check("stall_hold_cnt", 32'(InstrCount), 32'd1);
        Enable = 1'b1; tick();  // EXEC pc1
        check("stall_e1_pc", 32'(AddrProg), 32'd1);
        Enable = 1'b0; tick();
        check("stall_f2_pc", 32'(AddrProg), 32'd2);
        check("stall_f2_cnt", 32'(InstrCount), 32'd2);

        // PC wrap through a ROM of NOPs (opcode 11111, operand 0x7FF).
        fill_rom(16'hFFFF);
        do_reset();
        Enable = 1'b1;
        for (int i = 0; i < 4094; i++) tick();
        check("wrap_pc_max", 32'(AddrProg), 32'd2047);
        check("wrap_cnt_pre", 32'(InstrCount), 32'd2047);
        tick();
        check("wrap_nop_ctrl", 32'(ctrl), 32'h0);
        check("wrap_nop_opnd", 32'(Operand), 32'h7FF);
        tick();
        check("wrap_pc", 32'(AddrProg), 32'd0);
        check("wrap_cnt", 32'(InstrCount), 32'd2048);

        // Reset during EXEC of ADDI, with Enable still high.
        fill_rom(16'hF800);
        rom[0] = 16'h2803;
        do_reset();
        Enable = 1'b1;
        tick();
        check("rexec_wracc", 32'(WrAcc), 32'h1);
        reset = 1'b1;
        tick();
        check("rexec_pc", 32'(AddrProg), 32'd0);
        check("rexec_cnt", 32'(InstrCount), 32'd0);
        check("rexec_wracc_off", 32'(WrAcc), 32'h0);
        check("rexec_ctrl", 32'(ctrl), 32'h0);
        reset = 1'b0;
        tick();  // FETCH -> EXEC again
        check("rexec_again", 32'(WrAcc), 32'h1);
        tick();
        check("rexec_again_pc", 32'(AddrProg), 32'd1);
        check("rexec_again_cnt", 32'(InstrCount), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
